// File: rtl/st_reg_pkg.sv
// Shared types and constants for the envelope-state register scheduler.
package st_reg_pkg;

  localparam int ST_W = 107;

  // State word layout, MSB first: level, oldlevel, distance, st.
  localparam int LEVEL_W      = 32;
  localparam int OLDLEVEL_W   = 32;
  localparam int DISTANCE_W   = 32;
  localparam int ST_FIELD_W   = 11;
  localparam int ST_LSB       = 0;
  localparam int DISTANCE_LSB = ST_LSB + ST_FIELD_W;
  localparam int OLDLEVEL_LSB = DISTANCE_LSB + DISTANCE_W;
  localparam int LEVEL_LSB    = OLDLEVEL_LSB + OLDLEVEL_W;

  typedef enum logic [2:0] {
    IDLE,
    HOST_A,
    HOST_W,
    SWEEP,
    DRAIN,
    HOST_R
  } sched_state_t;

endpackage

// File: rtl/st_reg_sched_pipe.sv
// Valid/slot shift register tracking in-flight sweep reads, plus the
// writeback register that captures the datapath result.
module st_reg_sched_pipe
  import st_reg_pkg::*;
#(
  parameter int UPD_LAT = 2,
  parameter int AW      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [AW-1:0]   in_slot,
  input  logic [ST_W-1:0] upd_result,
  output logic            upd_valid,
  output logic [AW-1:0]   upd_slot,
  output logic            wb_addr_valid,
  output logic [AW-1:0]   wb_addr,
  output logic            wb_valid,
  output logic [ST_W-1:0] wb_data,
  output logic            pipe_busy
);

  localparam int DEPTH = 2 + UPD_LAT;

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    slot_sr [DEPTH];

  // Stage i holds the read issued i+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld      <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      for (int i = 0; i < DEPTH; i++) slot_sr[i] <= '0;
    end else begin
      vld        <= {vld[DEPTH-2:0], in_valid};
      slot_sr[0] <= in_slot;
      for (int i = 1; i < DEPTH; i++) slot_sr[i] <= slot_sr[i-1];
      wb_valid   <= vld[DEPTH-1];
      if (vld[DEPTH-1]) wb_data <= upd_result;
    end
  end

  assign upd_valid     = vld[1];
  assign upd_slot      = slot_sr[1];
  assign wb_addr_valid = vld[DEPTH-1];
  assign wb_addr       = slot_sr[DEPTH-1];
  assign pipe_busy     = |vld;

endmodule

// File: rtl/st_reg_sched.sv
// Envelope-state RAM scheduler: per-tick read/update/writeback sweep and host writes.
// Optional host read port enabled by defining ST_REG_HOST_RD_EN.
module st_reg_sched
  import st_reg_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int UPD_LAT = 2,
  localparam int AW     = V_WIDTH + E_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            host_req,
  input  logic [AW-1:0]   host_slot,
  input  logic [ST_W-1:0] host_data,
  output logic            host_ack,
  output logic [AW-1:0]   ram_raddr,
  input  logic [ST_W-1:0] ram_q,
  output logic [AW-1:0]   ram_waddr,
  output logic [ST_W-1:0] ram_d,
  output logic            ram_we,
  output logic            upd_valid,
  output logic [AW-1:0]   upd_slot,
  output logic [ST_W-1:0] upd_state,
  input  logic [ST_W-1:0] upd_result,
  output logic            busy,
  output logic            done,
  output logic            overrun
`ifdef ST_REG_HOST_RD_EN
  ,
  input  logic            host_rd_req,
  output logic            host_rd_valid,
  output logic [ST_W-1:0] host_rd_data
`endif
);

  localparam int N  = VOICES * V_ENVS;
  localparam int CW = AW + 1;

  sched_state_t state, next_state;

  logic [CW-1:0] rd_cnt;
  logic [AW-1:0] raddr_hold;
  logic          pending_tick;
  logic          rd_fire;
  logic          wb_addr_valid;
  logic [AW-1:0] wb_addr;
  logic          wb_valid;
  logic [ST_W-1:0] wb_data;
  logic          pipe_busy;
`ifdef ST_REG_HOST_RD_EN
  logic [1:0]    rd_wait;
`endif

  st_reg_sched_pipe #(
    .UPD_LAT(UPD_LAT),
    .AW     (AW)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (rd_fire),
    .in_slot      (rd_cnt[AW-1:0]),
    .upd_result   (upd_result),
    .upd_valid    (upd_valid),
    .upd_slot     (upd_slot),
    .wb_addr_valid(wb_addr_valid),
    .wb_addr      (wb_addr),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .pipe_busy    (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Sweep counter, read-address hold, tick bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt       <= '0;
      raddr_hold   <= '0;
      pending_tick <= 1'b0;
      overrun      <= 1'b0;
      done         <= 1'b0;
`ifdef ST_REG_HOST_RD_EN
      rd_wait      <= 2'd0;
`endif
    end else begin
      rd_cnt     <= (state == SWEEP) ? rd_cnt + CW'(1) : '0;
      raddr_hold <= ram_raddr;
      if (state == IDLE && next_state == SWEEP)
        pending_tick <= 1'b0;
      else if (tick && state != SWEEP && state != DRAIN)
        pending_tick <= 1'b1;
      if (tick && (state == SWEEP || state == DRAIN))
        overrun <= 1'b1;
      done <= (state == DRAIN) && (next_state == IDLE);
`ifdef ST_REG_HOST_RD_EN
      rd_wait <= (state == HOST_R) ? rd_wait + 2'd1 : 2'd0;
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (host_req)
          next_state = HOST_A;
`ifdef ST_REG_HOST_RD_EN
        else if (host_rd_req)
          next_state = HOST_R;
`endif
        else if (pending_tick || tick)
          next_state = SWEEP;
      end
      HOST_A: next_state = HOST_W;
      HOST_W: next_state = IDLE;
      SWEEP: begin
        if (rd_cnt == CW'(N - 1)) next_state = DRAIN;
      end
      // Leave once the final writeback is on the RAM port and nothing trails it.
      DRAIN: begin
        if (wb_valid && !pipe_busy) next_state = IDLE;
      end
`ifdef ST_REG_HOST_RD_EN
      HOST_R: begin
        if (rd_wait == 2'd2) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_raddr = raddr_hold;
    ram_waddr = '0;
    ram_d     = '0;
    ram_we    = 1'b0;
    host_ack  = 1'b0;
    rd_fire   = 1'b0;
    busy      = (state != IDLE);
`ifdef ST_REG_HOST_RD_EN
    host_rd_valid = 1'b0;
    host_rd_data  = '0;
`endif
    case (state)
      SWEEP: begin
        ram_raddr = rd_cnt[AW-1:0];
        rd_fire   = 1'b1;
      end
      HOST_A: ram_waddr = host_slot;
      HOST_W: begin
        ram_we   = 1'b1;
        ram_d    = host_data;
        host_ack = 1'b1;
      end
`ifdef ST_REG_HOST_RD_EN
      HOST_R: begin
        if (rd_wait == 2'd0) ram_raddr = host_slot;
        if (rd_wait == 2'd2) begin
          host_rd_valid = 1'b1;
          host_rd_data  = ram_q;
        end
      end
`endif
      default: ;
    endcase
    // Host states are only entered from IDLE, so they never overlap writeback.
    if (wb_addr_valid) ram_waddr = wb_addr;
    if (wb_valid) begin
      ram_we = 1'b1;
      ram_d  = wb_data;
    end
  end

  assign upd_state = upd_valid ? ram_q : '0;

endmodule

// File: tb/tb_st_reg_sched.sv
// Randomized self-checking bench for st_reg_sched with a RAM and datapath model.
module tb_st_reg_sched;
  import st_reg_pkg::*;

  localparam int AW = 6;
  localparam int N  = 64;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset, tick, host_req;
  logic [AW-1:0]   host_slot;
  logic [ST_W-1:0] host_data;
  logic            host_ack;
  logic [AW-1:0]   ram_raddr, ram_waddr;
  logic [ST_W-1:0] ram_q, ram_d;
  logic            ram_we;
  logic            upd_valid;
  logic [AW-1:0]   upd_slot;
  logic [ST_W-1:0] upd_state, upd_result;
  logic            busy, done, overrun;
`ifdef ST_REG_HOST_RD_EN
  logic            host_rd_req = 1'b0;
  logic            host_rd_valid;
  logic [ST_W-1:0] host_rd_data;
`endif

  always #5 clk = ~clk;

  st_reg_sched dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .host_req  (host_req),
    .host_slot (host_slot),
    .host_data (host_data),
    .host_ack  (host_ack),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q),
    .ram_waddr (ram_waddr),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .upd_valid (upd_valid),
    .upd_slot  (upd_slot),
    .upd_state (upd_state),
    .upd_result(upd_result),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef ST_REG_HOST_RD_EN
    ,
    .host_rd_req  (host_rd_req),
    .host_rd_valid(host_rd_valid),
    .host_rd_data (host_rd_data)
`endif
  );

  // RAM model: two-cycle registered read, write address leads we/d by one cycle.
  logic [ST_W-1:0] mem [N];
  logic [ST_W-1:0] preload_img [N];
  logic            preload_go = 1'b0;
  logic [AW-1:0]   ra1, wa1;

  always @(posedge clk) begin
    ra1   <= ram_raddr;
    ram_q <= mem[ra1];
    wa1   <= ram_waddr;
    if (preload_go) begin
      for (int k = 0; k < N; k++) mem[k] <= preload_img[k];
    end else if (ram_we) begin
      mem[wa1] <= ram_d;
    end
  end

  // Datapath model: result = state + incr, UPD_LAT cycles later.
  logic [ST_W-1:0] dp [L];
  int unsigned     incr = 1;

  always @(posedge clk) begin
    dp[0] <= upd_state + ST_W'(incr);
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign upd_result = dp[L-1];

  logic [ST_W-1:0] exp_ram [N];
  int total = 0;
  int bad   = 0;
  bit ov_sticky = 1'b0;

  function automatic logic [ST_W-1:0] rand107();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[ST_W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [ST_W-1:0] got,
                             input logic [ST_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic hr,
                               input logic [AW-1:0] s, input logic [ST_W-1:0] d);
    tick      = t;
    host_req  = hr;
    host_slot = s;
    host_data = d;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    ov_sticky = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadRam(input bit seq);
    for (int k = 0; k < N; k++) begin
      preload_img[k] = seq ? ST_W'(k) : rand107();
      exp_ram[k]     = preload_img[k];
    end
    preload_go = 1'b1;
    @(negedge clk);
    preload_go = 1'b0;
  endtask

  task automatic checkRam(input string tag);
    for (int k = 0; k < N; k++) checkOutput(tag, mem[k], exp_ram[k]);
  endtask

  task automatic hostWrite(input logic [AW-1:0] s, input logic [ST_W-1:0] d);
    applyStimulus(1'b0, 1'b1, s, d);
    @(negedge clk);
    checkOutput("hostA_waddr", ST_W'(ram_waddr), ST_W'(s));
    checkOutput("hostA_we", ST_W'(ram_we), '0);
    checkOutput("hostA_ack", ST_W'(host_ack), '0);
    @(negedge clk);
    checkOutput("hostW_we", ST_W'(ram_we), ST_W'(1));
    checkOutput("hostW_d", ram_d, d);
    checkOutput("hostW_ack", ST_W'(host_ack), ST_W'(1));
    host_req = 1'b0;
    @(negedge clk);
    checkOutput("host_idle", ST_W'(busy), '0);
    exp_ram[s] = d;
  endtask

  // Cycle 0 is the first SWEEP cycle; ovAt/rstAt < 0 disable the extra tick / reset.
  task automatic runTimedSweep(input int ovAt, input int rstAt);
    bit aborted = 1'b0;
    logic [ST_W-1:0] pre [N];
    for (int k = 0; k < N; k++) pre[k] = exp_ram[k];
    applyStimulus(1'b1, 1'b0, '0, '0);
    @(negedge clk);
    for (int c = 0; c <= N + 3 + L; c++) begin
      if (rstAt >= 0 && c == rstAt + 1) begin
        checkOutput("rst_busy", ST_W'(busy), '0);
        checkOutput("rst_we", ST_W'(ram_we), '0);
        checkOutput("rst_uv", ST_W'(upd_valid), '0);
        checkOutput("rst_ovr", ST_W'(overrun), '0);
        reset     = 1'b0;
        ov_sticky = 1'b0;
        aborted   = 1'b1;
        break;
      end
      checkOutput("sw_raddr", ST_W'(ram_raddr), ST_W'((c < N) ? c : N - 1));
      checkOutput("sw_uvalid", ST_W'(upd_valid), ST_W'(c >= 2 && c < N + 2));
      if (c >= 2 && c < N + 2) begin
        checkOutput("sw_uslot", ST_W'(upd_slot), ST_W'(c - 2));
        checkOutput("sw_ustate", upd_state, pre[c-2]);
      end
      checkOutput("sw_we", ST_W'(ram_we), ST_W'(c >= L + 3 && c <= N + 2 + L));
      checkOutput("sw_done", ST_W'(done), ST_W'(c == N + 3 + L));
      checkOutput("sw_busy", ST_W'(busy), ST_W'(c < N + 3 + L));
      checkOutput("sw_ovr", ST_W'(overrun), ST_W'(ov_sticky || (ovAt >= 0 && c > ovAt)));
      tick = (c == ovAt);
      if (c == rstAt) reset = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
    if (aborted) begin
      for (int k = 0; k < N; k++)
        if (k + L + 3 <= rstAt) exp_ram[k] = pre[k] + ST_W'(incr);
    end else begin
      for (int k = 0; k < N; k++) exp_ram[k] = pre[k] + ST_W'(incr);
      if (ovAt >= 0) ov_sticky = 1'b1;
    end
  endtask

  initial begin
    logic [AW-1:0]   s;
    logic [ST_W-1:0] d;
    bit got_ack, got_done;

    resetDut();
    checkOutput("rst_busy0", ST_W'(busy), '0);
    checkOutput("rst_we0", ST_W'(ram_we), '0);
    checkOutput("rst_done0", ST_W'(done), '0);
    checkOutput("rst_ovr0", ST_W'(overrun), '0);
    checkOutput("rst_ack0", ST_W'(host_ack), '0);
    checkOutput("rst_raddr0", ST_W'(ram_raddr), '0);

    $display("[TB] sweep with slot k = k, datapath +1");
    incr = 1;
    loadRam(1'b1);
    runTimedSweep(-1, -1);
    checkRam("ram_seq");

    $display("[TB] host writes");
    hostWrite(AW'(9), ST_W'('h5A));
    checkOutput("host_rb9", mem[9], ST_W'('h5A));
    repeat (3) hostWrite(AW'($urandom_range(0, N - 1)), rand107());
    checkRam("ram_host");

    $display("[TB] random contents sweep");
    loadRam(1'b0);
    incr = $urandom_range(1, 1000);
    runTimedSweep(-1, -1);
    checkRam("ram_rand");

    $display("[TB] tick together with host_req");
    incr = $urandom_range(1, 1000);
    s = AW'($urandom_range(0, N - 1));
    d = rand107();
    applyStimulus(1'b1, 1'b1, s, d);
    @(negedge clk);
    tick = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      if (host_ack) begin
        got_ack  = 1'b1;
        host_req = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("th_ack", ST_W'(got_ack), ST_W'(1));
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("th_done", ST_W'(got_done), ST_W'(1));
    exp_ram[s] = d;
    for (int k = 0; k < N; k++) exp_ram[k] = exp_ram[k] + ST_W'(incr);
    checkRam("ram_tickhost");
    checkOutput("th_ovr", ST_W'(overrun), '0);

    $display("[TB] second tick mid-sweep");
    incr = $urandom_range(1, 1000);
    runTimedSweep(30, -1);
    repeat (10) begin
      checkOutput("ov_idle", ST_W'(busy), '0);
      checkOutput("ov_sticky", ST_W'(overrun), ST_W'(1));
      @(negedge clk);
    end
    checkRam("ram_ovr");

    $display("[TB] reset mid-sweep");
    incr = $urandom_range(1, 1000);
    runTimedSweep(-1, 20);
    @(negedge clk);
    checkRam("ram_rstmid");
    incr = $urandom_range(1, 1000);
    runTimedSweep(-1, -1);
    checkRam("ram_after_rst");

`ifdef ST_REG_HOST_RD_EN
    $display("[TB] host read");
    host_slot   = AW'(3);
    host_rd_req = 1'b1;
    @(negedge clk);
    host_rd_req = 1'b0;
    checkOutput("hr_v0", ST_W'(host_rd_valid), '0);
    @(negedge clk);
    checkOutput("hr_v1", ST_W'(host_rd_valid), '0);
    @(negedge clk);
    checkOutput("hr_v2", ST_W'(host_rd_valid), ST_W'(1));
    checkOutput("hr_data", host_rd_data, exp_ram[3]);
    @(negedge clk);
    checkOutput("hr_idle", ST_W'(busy), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
